// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with an optional 2-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL2 = 2'd2
  } state_t;

  localparam logic             USE_SKID  = (SKID != 0);
  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             in_ready_r;
  logic [CNT_W-1:0] stall_r;
  logic             in_ready_s;
  logic             acc_s;
  logic             dep_s;
  logic             load_main_s;
  logic             load_skid_s;
  logic             pop_skid_s;

  assign out_valid = (state_r != EMPTY);
  assign out_data  = main_r;
  assign occupancy = state_r;
  assign stall_cnt = stall_r;
  assign in_ready  = in_ready_s;
  assign acc_s     = in_valid & in_ready_s;
  assign dep_s     = out_valid & out_ready;

  // State register; the skid build precomputes in_ready from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s != FULL2);
    end
  end

  // Next-state and payload-steering decode; flush overrides every transfer.
  always_comb begin
    state_nxt_s = state_r;
    load_main_s = 1'b0;
    load_skid_s = 1'b0;
    pop_skid_s  = 1'b0;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (acc_s) begin
            state_nxt_s = ONE;
            load_main_s = 1'b1;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (acc_s && dep_s) begin
            state_nxt_s = ONE;
            load_main_s = 1'b1;
          end else if (acc_s && USE_SKID) begin
            state_nxt_s = FULL2;
            load_skid_s = 1'b1;
          end else if (dep_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
        end
        FULL2: begin
          if (dep_s) begin
            state_nxt_s = ONE;
            pop_skid_s  = 1'b1;
          end else begin
            state_nxt_s = FULL2;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  // Upstream ready: registered with the skid buffer, otherwise pass-through of downstream.
  always_comb begin
    in_ready_s = 1'b1;
    if (USE_SKID) begin
      in_ready_s = in_ready_r;
    end else begin
      in_ready_s = ~out_valid | out_ready;
    end
  end

  // Payload registers; contents are left untouched on flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_r <= '0;
      skid_r <= '0;
    end else begin
      if (load_main_s) begin
        main_r <= in_data;
      end else if (pop_skid_s) begin
        main_r <= skid_r;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= in_data;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  // Saturating count of cycles where downstream withholds ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_r <= '0;
    end else if (flush) begin
      stall_r <= '0;
    end else if (out_valid && !out_ready && (stall_r != STALL_MAX)) begin
      stall_r <= stall_r + STALL_ONE;
    end else begin
      stall_r <= stall_r;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboard bench for pipe_stage_reg; index 0 is the SKID=0
// build, index 1 the SKID=1 build, both with CNT_W=4.
module tb_pipe_stage_reg;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       fl, iv, ordy, ir, ov;
  logic [1:0][15:0] id, od;
  logic [1:0][1:0]  occ;
  logic [1:0][3:0]  sc;
  int checks = 0;
  int failures = 0;
  int nxt [2];
  int got [2];
  logic [1:0] acc_f;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(16), .SKID(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .reset_n(rst_n), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .occupancy(occ[0]), .stall_cnt(sc[0]));

  pipe_stage_reg #(.WIDTH(16), .SKID(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset_n(rst_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .occupancy(occ[1]), .stall_cnt(sc[1]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_sb();
    for (int k = 0; k < 2; k++) begin
      acc_f[k] = iv[k] & ir[k];
      if (acc_f[k]) nxt[k]++;
      if (ov[k] && ordy[k]) begin
        check_eq($sformatf("sb_order k%0d", k), {16'h0, od[k]}, {16'h0, got[k][15:0]});
        got[k]++;
      end
      if (k == 0) check_eq("sb_occ_max k0", {31'h0, (occ[0] <= 2'd1)}, 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; fl = '0; iv = '0; ordy = '0; id = '0;
    #12;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_ov k%0d", k), ov[k], 0);
      check_eq($sformatf("rst_ir k%0d", k), ir[k], 1);
      check_eq($sformatf("rst_occ k%0d", k), occ[k], 0);
      check_eq($sformatf("rst_sc k%0d", k), sc[k], 0);
      check_eq($sformatf("rst_od k%0d", k), od[k], 0);
    end
    #5 rst_n = 1'b1;

    // Streaming, both builds
    for (int k = 0; k < 2; k++) begin
      tick();
      ordy[k] = 1'b1; iv[k] = 1'b1;
      for (int i = 0; i < 100; i++) begin
        id[k] = 16'(i);
        tick();
        check_eq($sformatf("stream_od k%0d", k), od[k], i);
        check_eq($sformatf("stream_ov k%0d", k), ov[k], 1);
        check_eq($sformatf("stream_ir k%0d", k), ir[k], 1);
      end
      iv[k] = 1'b0;
      tick();
      check_eq($sformatf("stream_drain k%0d", k), ov[k], 0);
      ordy[k] = 1'b0;
    end

    // Backpressure, SKID=1
    iv[1] = 1'b1; id[1] = 16'h00A0;
    tick();
    check_eq("bp1_a_od", od[1], 32'hA0);
    check_eq("bp1_a_ir", ir[1], 1);
    check_eq("bp1_a_occ", occ[1], 1);
    id[1] = 16'h00B0;
    tick();
    check_eq("bp1_b_occ", occ[1], 2);
    check_eq("bp1_b_ir", ir[1], 0);
    check_eq("bp1_b_od", od[1], 32'hA0);
    id[1] = 16'h00C0;
    tick();
    check_eq("bp1_hold_occ", occ[1], 2);
    check_eq("bp1_hold_ir", ir[1], 0);
    check_eq("bp1_hold_sc", sc[1], 2);
    ordy[1] = 1'b1;
    tick();
    check_eq("bp1_out_b", od[1], 32'hB0);
    check_eq("bp1_out_b_occ", occ[1], 1);
    check_eq("bp1_out_b_ir", ir[1], 1);
    tick();
    check_eq("bp1_out_c", od[1], 32'hC0);
    check_eq("bp1_out_c_ov", ov[1], 1);
    iv[1] = 1'b0;
    tick();
    check_eq("bp1_end_ov", ov[1], 0);
    check_eq("bp1_end_occ", occ[1], 0);
    check_eq("bp1_end_sc", sc[1], 2);
    ordy[1] = 1'b0;

    // Backpressure, SKID=0
    iv[0] = 1'b1; id[0] = 16'h00A0;
    #1 check_eq("bp0_empty_ir", ir[0], 1);
    tick();
    check_eq("bp0_a_ir", ir[0], 0);
    check_eq("bp0_a_occ", occ[0], 1);
    check_eq("bp0_a_od", od[0], 32'hA0);
    id[0] = 16'h00B0;
    tick();
    check_eq("bp0_hold_od", od[0], 32'hA0);
    check_eq("bp0_hold_occ", occ[0], 1);
    ordy[0] = 1'b1;
    #1 check_eq("bp0_comb_ir", ir[0], 1);
    tick();
    check_eq("bp0_out_b", od[0], 32'hB0);
    check_eq("bp0_out_b_occ", occ[0], 1);
    id[0] = 16'h00C0;
    tick();
    check_eq("bp0_out_c", od[0], 32'hC0);
    iv[0] = 1'b0;
    tick();
    check_eq("bp0_end_ov", ov[0], 0);
    ordy[0] = 1'b0;

    // Flush from FULL2 with a same-cycle input, then flush during acc&dep
    iv[1] = 1'b1; id[1] = 16'h0011;
    tick();
    id[1] = 16'h0022;
    tick();
    check_eq("fl_pre_occ", occ[1], 2);
    fl[1] = 1'b1; id[1] = 16'h0033;
    tick();
    fl[1] = 1'b0; iv[1] = 1'b0;
    check_eq("fl_ov", ov[1], 0);
    check_eq("fl_occ", occ[1], 0);
    check_eq("fl_sc", sc[1], 0);
    check_eq("fl_ir", ir[1], 1);
    ordy[1] = 1'b1;
    tick();
    check_eq("fl_no_ghost", ov[1], 0);
    iv[1] = 1'b1; id[1] = 16'h0044;
    tick();
    check_eq("fl_44", od[1], 32'h44);
    id[1] = 16'h0055; fl[1] = 1'b1;
    tick();
    fl[1] = 1'b0; iv[1] = 1'b0;
    check_eq("fl_acc_ov", ov[1], 0);
    check_eq("fl_acc_occ", occ[1], 0);
    tick();
    check_eq("fl_acc_gone", ov[1], 0);
    iv[1] = 1'b1; id[1] = 16'h0066;
    tick();
    check_eq("fl_after_od", od[1], 32'h66);
    check_eq("fl_after_ov", ov[1], 1);
    iv[1] = 1'b0;
    tick();
    ordy[1] = 1'b0;

    // Stall counter saturation, both builds
    for (int k = 0; k < 2; k++) begin
      fl[k] = 1'b1;
      tick();
      fl[k] = 1'b0;
      check_eq($sformatf("st_clr k%0d", k), sc[k], 0);
      iv[k] = 1'b1; id[k] = 16'h0077;
      tick();
      iv[k] = 1'b0;
      check_eq($sformatf("st_start k%0d", k), sc[k], 0);
      for (int i = 1; i <= 20; i++) begin
        tick();
        check_eq($sformatf("st_cnt k%0d i%0d", k, i), sc[k], (i < 15) ? i : 15);
      end
      check_eq($sformatf("st_od k%0d", k), od[k], 32'h77);
      ordy[k] = 1'b1;
      tick();
      check_eq($sformatf("st_drain_ov k%0d", k), ov[k], 0);
      check_eq($sformatf("st_keep k%0d", k), sc[k], 15);
      fl[k] = 1'b1;
      tick();
      fl[k] = 1'b0; ordy[k] = 1'b0;
      check_eq($sformatf("st_flush k%0d", k), sc[k], 0);
    end

    // Async reset with SKID=1 held in FULL2
    iv[1] = 1'b1; id[1] = 16'h0088;
    tick();
    id[1] = 16'h0099;
    tick();
    iv[1] = 1'b0;
    check_eq("ar_pre_occ", occ[1], 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_ov", ov[1], 0);
    check_eq("ar_ir", ir[1], 1);
    check_eq("ar_occ", occ[1], 0);
    check_eq("ar_sc", sc[1], 0);
    #3 rst_n = 1'b1;

    // Random valid/ready scoreboard on both builds
    nxt[0] = 256; nxt[1] = 256; got[0] = 256; got[1] = 256; acc_f = '0;
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (acc_f[k] || !iv[k]) begin
          iv[k] = 1'($urandom_range(0, 1));
          id[k] = nxt[k][15:0];
        end
        ordy[k] = 1'($urandom_range(0, 1));
      end
      #1 sample_sb();
    end
    tick();
    iv = '0; ordy = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1 sample_sb();
      tick();
    end
    for (int k = 0; k < 2; k++)
      check_eq($sformatf("sb_count k%0d", k), got[k], nxt[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
